// File: rtl/apb_pkg.sv
// Shared types for the APB4 requester: FSM states, command and response payloads.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;
  localparam int unsigned APB_PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [APB_PROT_W-1:0] prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_rsp_t;

endpackage

// File: rtl/apb_req_timeout.sv
// ACCESS-phase wait counter; at_limit_c flags the last allowed wait cycle.
// Compiled only when APB_REQ_TIMEOUT_EN is defined.
`ifdef APB_REQ_TIMEOUT_EN
module apb_req_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic at_limit_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Saturating count of PREADY=0 cycles since ACCESS was entered.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                        cnt_d = '0;
    else if (count_i && cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
  end

  // This wait cycle is the one that makes the count reach the limit.
  assign at_limit_c = (cnt_q == LIMIT_M1);

endmodule
`endif

// File: rtl/apb_requester.sv
// APB4 requester: valid/ready command stream in, SETUP/ACCESS transfers out, one-entry response.
// Optional ACCESS wait limit via APB_REQ_TIMEOUT_EN.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_slverr,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [2:0]            PPROT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PSLVERR
);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_q, cmd_d;
  apb_rsp_t   rsp_q, rsp_d;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       accept_c, done_c, timeout_c;

  // A new command is taken only from IDLE and only if the response slot is or becomes free.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready) && !PRESET;
  assign accept_c  = cmd_valid && cmd_ready;
  assign done_c    = (state_q == ACCESS) && PREADY;

`ifdef APB_REQ_TIMEOUT_EN
  logic at_limit_c;

  apb_req_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .clear_i    (state_q == SETUP),
    .count_i    ((state_q == ACCESS) && !PREADY),
    .at_limit_c (at_limit_c)
  );

  // PREADY on the limit cycle wins because timeout_c requires PREADY=0.
  assign timeout_c = (state_q == ACCESS) && !PREADY && at_limit_c;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done_c || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_d.write = cmd_write;
          cmd_d.addr  = APB_ADDR_W'(cmd_addr);
          cmd_d.wdata = cmd_write ? APB_DATA_W'(cmd_wdata) : '0;
          cmd_d.strb  = cmd_write ? APB_STRB_W'(cmd_strb) : '0;
          cmd_d.prot  = cmd_prot;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (done_c) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_d.rdata  = cmd_q.write ? '0 : APB_DATA_W'(PRDATA);
          rsp_d.slverr = PSLVERR;
        end else if (timeout_c) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_d.rdata  = '0;
          rsp_d.slverr = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = cmd_q.write;
  assign PADDR      = ADDR_W'(cmd_q.addr);
  assign PWDATA     = DATA_W'(cmd_q.wdata);
  assign PSTRB      = (DATA_W/8)'(cmd_q.strb);
  assign PPROT      = cmd_q.prot;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = DATA_W'(rsp_q.rdata);
  assign rsp_slverr = rsp_q.slverr;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: simple completer, transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_requester;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TO     = 16;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid, rsp_ready, rsp_slverr;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] PADDR;
  logic [2:0]        PPROT;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic [STRB_W-1:0] PSTRB;

  apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Completer: register file plus a FIFO port at PADDR[31]=1; 0x40 answers with PSLVERR.
  logic [31:0] regs [0:63];
  logic [31:0] fifo_mem [0:15];
  logic [3:0]  fifo_wp, fifo_rp;
  int          acc_cnt;
  int          waits;
  logic        hang, cpl_init;

  always_comb begin
    PREADY  = !hang && (acc_cnt >= waits);
    PRDATA  = '0;
    if (PSEL && !PWRITE) PRDATA = PADDR[31] ? fifo_mem[fifo_rp] : regs[PADDR[7:2]];
    PSLVERR = PSEL && (PADDR == 32'h40);
  end

  always @(posedge PCLK) begin
    if (cpl_init) begin
      for (int i = 0; i < 64; i++) regs[i] <= 32'h0;
      regs[8]  <= 32'h15;
      regs[16] <= 32'hDEAD_BEEF;
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      acc_cnt  <= 0;
    end else begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY) begin
        if (PWRITE) begin
          if (PADDR[31]) begin
            fifo_mem[fifo_wp] <= PWDATA;
            fifo_wp <= fifo_wp + 4'd1;
          end else begin
            regs[PADDR[7:2]] <= PWDATA;
          end
        end else if (PADDR[31]) begin
          fifo_rp <= fifo_rp + 4'd1;
        end
      end
    end
  end

  // Transaction model: one outstanding transfer aged in cycles since acceptance, one response slot.
  logic        m_busy = 1'b0;
  int          m_age  = 0;
  logic        m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        exp_ready;
  logic [32:0] got_q [$];
  int          acc_seen = 0;

  always @(negedge PCLK) begin
    if (PRESET) begin
      m_busy      = 1'b0;
      m_rsp_valid = 1'b0;
      chk("reset_bus", 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}), 128'(0));
      chk("reset_rsp", 128'({rsp_valid, rsp_rdata, rsp_slverr}), 128'(0));
      chk("reset_cmd_ready", 128'(cmd_ready), 128'(0));
    end else begin
      exp_ready = !m_busy && (!m_rsp_valid || rsp_ready);
      chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
      chk("psel", 128'(PSEL), 128'(m_busy));
      chk("penable", 128'(PENABLE), 128'(m_busy && m_age >= 2));
      if (m_busy)
        chk("bus_cmd", 128'({PWRITE, PADDR, PWDATA, PSTRB, PPROT}),
            128'({m_write, m_addr, (m_write ? m_wdata : 32'h0), (m_write ? m_strb : 4'h0), m_prot}));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
      if (m_rsp_valid) chk("rsp_data", 128'({rsp_rdata, rsp_slverr}), 128'({m_rdata, m_err}));

      if (PSEL && PENABLE) acc_seen++;
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_rdata, rsp_slverr});

      if (m_rsp_valid && rsp_ready) m_rsp_valid = 1'b0;
      if (m_busy) begin
        if (m_age >= 2 && PREADY) begin
          m_busy      = 1'b0;
          m_rsp_valid = 1'b1;
          m_rdata     = m_write ? 32'h0 : PRDATA;
          m_err       = PSLVERR;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (m_age == int'(TO) + 1) begin
          m_busy      = 1'b0;
          m_rsp_valid = 1'b1;
          m_rdata     = 32'h0;
          m_err       = 1'b1;
        end
`endif
        else begin
          m_age++;
        end
      end else if (cmd_valid && exp_ready) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_write = cmd_write;
        m_addr  = cmd_addr;
        m_wdata = cmd_wdata;
        m_strb  = cmd_strb;
        m_prot  = cmd_prot;
      end
    end
  end

  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
  endtask

  // Present a command and return 1ns after the edge that accepted it (cycle 1 of the transfer).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    logic hs = 1'b0;
    int   n  = 0;
    set_cmd(w, a, d, s, p);
    cmd_valid = 1'b1;
    while (!hs && n < 60) begin
      @(negedge PCLK);
      hs = cmd_ready;
      @(posedge PCLK);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_handshake", 128'(hs), 128'(1));
  endtask

  task automatic wait_rsps(input int cnt, input int budget);
    int n = 0;
    while (got_q.size() < cnt && n < budget) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    chk("rsp_arrived", 128'(got_q.size() >= cnt), 128'(1));
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] er, input logic ee);
    logic [32:0] r;
    if (got_q.size() == 0) begin
      chk({nm, "_present"}, 128'(0), 128'(1));
    end else begin
      r = got_q.pop_front();
      chk(nm, 128'(r), 128'({er, ee}));
    end
  endtask

  task automatic take_rsp(input string nm, input logic [31:0] er, input logic ee);
    rsp_ready = 1'b1;
    wait_rsps(1, 60);
    rsp_ready = 1'b0;
    pop_chk(nm, er, ee);
  endtask

  initial begin
    PRESET = 1'b1; cpl_init = 1'b1; hang = 1'b0; waits = 0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    set_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0; cpl_init = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;

    // 1: zero-wait write, cycle-exact phases
    issue(1'b1, 32'h0, 32'h4, 4'hF, 3'h0);
    chk("t1_setup", 128'({PSEL, PENABLE}), 128'(2'b10));
    @(posedge PCLK); #1;
    chk("t1_access", 128'({PSEL, PENABLE}), 128'(2'b11));
    @(posedge PCLK); #1;
    chk("t1_rsp", 128'({rsp_valid, rsp_slverr, rsp_rdata, PSEL}), 128'({1'b1, 1'b0, 32'h0, 1'b0}));
    take_rsp("t1_pop", 32'h0, 1'b0);

    // 2: read with three wait states; write data/strobes presented must not reach the bus
    waits = 3; acc_seen = 0;
    issue(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b010);
    take_rsp("t2_rdata", 32'h15, 1'b0);
    chk("t2_access_cycles", 128'(acc_seen), 128'(4));
    waits = 0;

    // 3: error response held under backpressure while the next command waits
    issue(1'b0, 32'h40, 32'h0, 4'h0, 3'h1);
    set_cmd(1'b1, 32'h4, 32'h99, 4'h3, 3'h0);
    cmd_valid = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", 128'({rsp_valid, rsp_slverr, rsp_rdata, cmd_ready}), 128'({1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0}));
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("t3_next_setup", 128'({PSEL, PENABLE, PADDR}), 128'({1'b1, 1'b0, 32'h4}));
    pop_chk("t3_err", 32'hDEAD_BEEF, 1'b1);
    take_rsp("t3_wr", 32'h0, 1'b0);

    // 4: FIFO stream, 8 writes then 8 reads, back to back
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      issue(i < 8, 32'h8000_0000, (i < 8) ? 32'(i + 1) : 32'h0, 4'hF, 3'h0);
    wait_rsps(16, 40);
    for (int i = 0; i < 16; i++)
      pop_chk("t4_stream", (i < 8) ? 32'h0 : 32'(i - 7), 1'b0);

    // 5: asynchronous reset in the middle of ACCESS
    hang = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 3'h0);
    @(posedge PCLK); #2;
    PRESET = 1'b1;
    #1;
    chk("t5_drop", 128'({PSEL, PENABLE, rsp_valid, cmd_ready}), 128'(0));
    @(posedge PCLK); #3;
    PRESET = 1'b0; hang = 1'b0;
    chk("t5_no_rsp", 128'(got_q.size()), 128'(0));
    issue(1'b1, 32'h8, 32'hA5, 4'hF, 3'h0);
    wait_rsps(1, 20);
    pop_chk("t5_wr", 32'h0, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'h0, 3'h0);
    wait_rsps(1, 20);
    pop_chk("t5_rd", 32'hA5, 1'b0);

    // 6: completer never ready
    hang = 1'b1; acc_seen = 0;
    issue(1'b0, 32'hC, 32'h0, 4'h0, 3'h0);
`ifdef APB_REQ_TIMEOUT_EN
    wait_rsps(1, 40);
    pop_chk("t6_timeout", 32'h0, 1'b1);
    chk("t6_access_cycles", 128'(acc_seen), 128'(TO));
    hang = 1'b0;
`else
    repeat (100) @(posedge PCLK);
    #1;
    chk("t6_no_rsp", 128'({got_q.size() != 0, rsp_valid}), 128'(0));
    PRESET = 1'b1;
    @(posedge PCLK); #3;
    PRESET = 1'b0; hang = 1'b0;
`endif
    issue(1'b0, 32'h20, 32'h0, 4'h0, 3'h0);
    wait_rsps(1, 20);
    pop_chk("t6_recover", 32'h15, 1'b0);
    rsp_ready = 1'b0;
    repeat (3) @(posedge PCLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
